// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED driver: off/on/static PWM/breathing; breathing enabled by LED_PWM_BREATH_EN
module led_pwm_ctrl #(
    parameter int NUM_CH   = 8,
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 16,
    parameter int STEP     = 1,
    localparam int CH_AW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              wr_en,
    input  logic [CH_AW-1:0]  wr_addr,
    input  logic [1:0]        wr_mode,
    input  logic [PWM_W-1:0]  wr_duty,
    output logic [NUM_CH-1:0] LED,
    output logic              period_strb,
    output logic              wr_err
);
    localparam int              PS_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PRESCALE - 1);
    localparam logic [CH_AW:0]  CH_LIMIT    = (CH_AW + 1)'(NUM_CH);
    localparam logic [1:0]      MODE_OFF    = 2'd0;
    localparam logic [1:0]      MODE_ON     = 2'd1;
    localparam logic [1:0]      MODE_PWM    = 2'd2;
    localparam logic [1:0]      MODE_BREATH = 2'd3;

    if (NUM_CH < 1 || NUM_CH > 32 || PWM_W < 2 || PWM_W > 16 || PRESCALE < 1 ||
        STEP < 1 || STEP > (2 ** PWM_W) - 1) begin : g_bad_params
        $error("led_pwm_ctrl: parameter out of range");
    end

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [PWM_W-1:0]  cnt_q, cnt_d;
    logic              strb_q, strb_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic              tick, boundary;

    logic [1:0]        sh_mode_q  [NUM_CH];
    logic [1:0]        sh_mode_d  [NUM_CH];
    logic [PWM_W-1:0]  sh_duty_q  [NUM_CH];
    logic [PWM_W-1:0]  sh_duty_d  [NUM_CH];
    logic [1:0]        act_mode_q [NUM_CH];
    logic [1:0]        act_mode_d [NUM_CH];
    logic [PWM_W-1:0]  act_duty_q [NUM_CH];
    logic [PWM_W-1:0]  act_duty_d [NUM_CH];

`ifdef LED_PWM_BREATH_EN
    localparam logic [PWM_W:0] STEP_X = (PWM_W + 1)'(STEP);
    logic [PWM_W-1:0]  level_q  [NUM_CH];
    logic [PWM_W-1:0]  level_d  [NUM_CH];
    logic              dir_up_q [NUM_CH];
    logic              dir_up_d [NUM_CH];
    logic              restart;
    logic              base_up;
    logic [PWM_W-1:0]  base_lvl;
    logic [PWM_W:0]    sum;
`endif

    assign tick        = (presc_q == PS_LAST);
    assign boundary    = tick && (cnt_q == '1);
    assign LED         = led_q;
    assign period_strb = strb_q;
    assign wr_err      = err_q;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        cnt_d   = tick ? cnt_q + PWM_W'(1) : cnt_q;
        strb_d  = boundary;
        err_d   = wr_en && ({1'b0, wr_addr} >= CH_LIMIT);
    end

    always_comb begin
        sh_mode_d  = sh_mode_q;
        sh_duty_d  = sh_duty_q;
        act_mode_d = act_mode_q;
        act_duty_d = act_duty_q;
        led_d      = '0;
`ifdef LED_PWM_BREATH_EN
        level_d  = level_q;
        dir_up_d = dir_up_q;
        restart  = 1'b0;
        base_up  = 1'b1;
        base_lvl = '0;
        sum      = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_addr == CH_AW'(i))) begin
                sh_mode_d[i] = wr_mode;
                sh_duty_d[i] = wr_duty;
            end
            // Apply takes the shadow as it stood at the start of the boundary cycle
            if (boundary) begin
                act_mode_d[i] = sh_mode_q[i];
                act_duty_d[i] = sh_duty_q[i];
            end
`ifdef LED_PWM_BREATH_EN
            if (boundary && (sh_mode_q[i] == MODE_BREATH)) begin
                restart  = (act_mode_q[i] != MODE_BREATH) || (act_duty_q[i] != sh_duty_q[i]);
                base_lvl = restart ? '0 : level_q[i];
                base_up  = restart ? 1'b1 : dir_up_q[i];
                if (base_up) begin
                    sum = {1'b0, base_lvl} + STEP_X;
                    if (sum >= {1'b0, sh_duty_q[i]}) begin
                        level_d[i]  = sh_duty_q[i];
                        dir_up_d[i] = 1'b0;
                    end else begin
                        level_d[i]  = sum[PWM_W-1:0];
                        dir_up_d[i] = 1'b1;
                    end
                end else if ({1'b0, base_lvl} <= STEP_X) begin
                    level_d[i]  = '0;
                    dir_up_d[i] = 1'b1;
                end else begin
                    level_d[i]  = base_lvl - STEP_X[PWM_W-1:0];
                    dir_up_d[i] = 1'b0;
                end
            end
`endif
            case (act_mode_q[i])
                MODE_OFF: led_d[i] = 1'b0;
                MODE_ON:  led_d[i] = 1'b1;
                MODE_PWM: led_d[i] = (cnt_q < act_duty_q[i]);
`ifdef LED_PWM_BREATH_EN
                default:  led_d[i] = (cnt_q < level_q[i]);
`else
                default:  led_d[i] = (cnt_q < act_duty_q[i]);
`endif
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            presc_q <= '0;
            cnt_q   <= '0;
            strb_q  <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_mode_q[i]  <= '0;
                sh_duty_q[i]  <= '0;
                act_mode_q[i] <= '0;
                act_duty_q[i] <= '0;
`ifdef LED_PWM_BREATH_EN
                level_q[i]    <= '0;
                dir_up_q[i]   <= 1'b1;
`endif
            end
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            strb_q     <= strb_d;
            err_q      <= err_d;
            led_q      <= led_d;
            sh_mode_q  <= sh_mode_d;
            sh_duty_q  <= sh_duty_d;
            act_mode_q <= act_mode_d;
            act_duty_q <= act_duty_d;
`ifdef LED_PWM_BREATH_EN
            level_q    <= level_d;
            dir_up_q   <= dir_up_d;
`endif
        end
    end
endmodule
